// File: rtl/serial_shift_in_pkg.sv
// Shared types and constants for the serial_shift_in receiver.
// Optional feature macro: SERIAL_SHIFT_IN_PARITY_EN (adds the PARITY state).
package serial_shift_in_pkg;

  localparam int FRAME_BITS = 8;
  localparam logic [2:0] LAST_BIT_IDX = 3'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SERIAL_SHIFT_IN_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

  // Even-parity bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] i_d);
    return ^i_d;
  endfunction

  // One shift step in the selected bit order.
  function automatic logic [7:0] shift_in(input logic [7:0] i_sr, input logic i_bit,
                                          input logic i_lsb_first);
    logic [7:0] w_res;
    if (i_lsb_first) begin
      w_res = {i_bit, i_sr[7:1]};
    end else begin
      w_res = {i_sr[6:0], i_bit};
    end
    return w_res;
  endfunction

endpackage

// File: rtl/serial_shift_in_if.sv
// Consumer-side bus of serial_shift_in: received byte, handshake and status.
// Optional feature macro: SERIAL_SHIFT_IN_PARITY_EN (adds parity_err).
interface serial_shift_in_if;

  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       busy;
  logic       overrun;
`ifdef SERIAL_SHIFT_IN_PARITY_EN
  logic       parity_err;
`endif

`ifdef SERIAL_SHIFT_IN_PARITY_EN
  modport slave  (input rd_ready, output rd_data, rd_valid, busy, overrun, parity_err);
  modport master (output rd_ready, input rd_data, rd_valid, busy, overrun, parity_err);
`else
  modport slave  (input rd_ready, output rd_data, rd_valid, busy, overrun);
  modport master (output rd_ready, input rd_data, rd_valid, busy, overrun);
`endif

endinterface

// File: rtl/serial_shift_in_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/serial_shift_in.sv
// Serial-to-parallel receiver: synchronizes sclk/sdata/cs_n, shifts 8-bit
// frames MSB- or LSB-first and hands bytes over a valid/ready holding register.
// Optional feature macro: SERIAL_SHIFT_IN_PARITY_EN (ninth even-parity bit).
module serial_shift_in
  import serial_shift_in_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sclk,
  input  logic               i_sdata,
  input  logic               i_cs_n,
  input  logic               i_lsb_first,
  serial_shift_in_if.slave   rd_if
);

  logic       w_sclk_s;
  logic       w_sdata_s;
  logic       w_cs_n_s;
  logic       w_sclk_rise;
  logic       w_shift;
  logic       w_load;
  state_t     w_state_nxt;

  state_t     r_state;
  logic       r_sclk_prev;
  logic [2:0] r_cnt;
  logic [7:0] r_sr;
  logic       r_lsb_first;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;
  logic       r_busy;
  logic       r_overrun;
`ifdef SERIAL_SHIFT_IN_PARITY_EN
  logic       r_parity_err;
`endif

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_sclk), .o_q(w_sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdata (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_sdata), .o_q(w_sdata_s)
  );

  // cs_n idles high so its chain resets to 1 to avoid a spurious frame start.
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_cs_n), .o_q(w_cs_n_s)
  );

  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_cs_n_s) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_cs_n_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_BIT_IDX) begin
`ifdef SERIAL_SHIFT_IN_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_DONE;
`endif
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
`ifdef SERIAL_SHIFT_IN_PARITY_EN
      ST_PARITY: begin
        if (w_cs_n_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
`endif
      ST_DONE: begin
        w_load = ~r_rd_valid | rd_if.rd_ready;
        if (!w_cs_n_s) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; busy is registered from the next state so it tracks the FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Edge detector history, frame setup, shift register and bit counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_prev <= 1'b0;
      r_cnt       <= 3'd0;
      r_sr        <= 8'h00;
      r_lsb_first <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk_s;
      if ((r_state == ST_IDLE) && !w_cs_n_s) begin
        r_lsb_first <= i_lsb_first;
        r_cnt       <= 3'd0;
      end else if (w_shift) begin
        r_sr  <= shift_in(r_sr, w_sdata_s, r_lsb_first);
        r_cnt <= r_cnt + 3'd1;
      end else if (r_state == ST_DONE) begin
        r_cnt <= 3'd0;
      end
    end
  end

  // Holding register handshake and sticky overrun on a discarded byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_load) begin
        r_rd_data  <= r_sr;
        r_rd_valid <= 1'b1;
      end else if (r_rd_valid && rd_if.rd_ready) begin
        r_rd_valid <= 1'b0;
      end
      if ((r_state == ST_DONE) && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef SERIAL_SHIFT_IN_PARITY_EN
  // Sticky flag when the received parity bit disagrees with the byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_parity_err <= 1'b0;
    end else if ((r_state == ST_PARITY) && !w_cs_n_s && w_sclk_rise &&
                 (w_sdata_s != even_parity(r_sr))) begin
      r_parity_err <= 1'b1;
    end
  end

  assign rd_if.parity_err = r_parity_err;
`endif

  assign rd_if.rd_data  = r_rd_data;
  assign rd_if.rd_valid = r_rd_valid;
  assign rd_if.busy     = r_busy;
  assign rd_if.overrun  = r_overrun;

endmodule

// File: doc/serial_shift_in.md
SERIAL_SHIFT_IN -- requirements
Module: serial_shift_in

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk, sdata and cs_n (legal values 2..3).
REQ-002 Port clk, input, 1: single system clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port sclk, input, 1: external serial clock, asynchronous to clk; data sampled on its rising edge.
REQ-005 Port sdata, input, 1: external serial data.
REQ-006 Port cs_n, input, 1: frame select, active low; asynchronous.
REQ-007 Port lsb_first, input, 1: 0 means first bit received is bit 7 (left shift-in), 1 means first bit is bit 0 (right shift-in); sampled at frame start.
REQ-008 Port rd_ready, input, 1: consumer accepts rd_data.
REQ-009 Port rd_data, output, 8: received byte.
REQ-010 Port rd_valid, output, 1: rd_data holds an unconsumed byte.
REQ-011 Port busy, output, 1: frame in progress.
REQ-012 Port overrun, output, 1: sticky; a byte completed while the holding register was still full.
REQ-013 Port parity_err, output, 1: sticky parity failure; present only with SERIAL_SHIFT_IN_PARITY_EN.

Function
REQ-014 sclk, sdata and cs_n SHALL each pass through a SYNC_STAGES-flop synchronizer; an sclk rise SHALL be detected as synchronized current 1 and previous 0.
REQ-015 The FSM SHALL have states IDLE, SHIFT, PARITY (macro only) and DONE.
REQ-016 IDLE->SHIFT on synchronized cs_n low; SHALL latch lsb_first, clear the 3-bit bit counter, and assert busy.
REQ-017 In SHIFT, each sclk rise SHALL shift sdata into the shift register: if lsb_first=0, sr <= {sr[6:0], sdata}; if 1, sr <= {sdata, sr[7:1]}; the counter SHALL increment.
REQ-018 The eighth sclk rise (counter 7) SHALL go to DONE (or to PARITY with the macro).
REQ-019 DONE SHALL last exactly one cycle: if rd_valid=0, or rd_valid=1 with rd_ready=1 in the same cycle, load rd_data and set rd_valid; otherwise discard the byte, keep the old rd_data, and set overrun. Next state SHALL be SHIFT if cs_n is still low (back-to-back bytes), else IDLE.
REQ-020 cs_n deasserting in SHIFT before eight bits SHALL abort: partial byte discarded, no rd_valid, return to IDLE, no flag set.
REQ-021 rd_valid SHALL clear on the cycle after rd_valid&rd_ready unless DONE loads a new byte in that same cycle, in which case it stays 1.
REQ-022 Latency from the eighth synchronized sclk rise to rd_valid SHALL be 2 clk cycles.
REQ-023 busy SHALL be 1 in SHIFT, PARITY and DONE, and 0 in IDLE.
REQ-024 sclk SHALL have high and low phases of at least SYNC_STAGES+1 clk cycles; faster sclk is outside spec.

Reset
REQ-025 reset SHALL force IDLE, clear the counter, shift register, rd_data (0x00), rd_valid, busy, overrun and parity_err, and all synchronizer flops (cs_n flops to 1); reset mid-frame SHALL discard the partial byte.
REQ-026 overrun and parity_err SHALL clear only on reset.

Configuration
REQ-027 With SERIAL_SHIFT_IN_PARITY_EN defined, a ninth sclk rise SHALL sample an even-parity bit in PARITY; a mismatch with ^sr SHALL still deliver the byte and set parity_err.
REQ-028 Without SERIAL_SHIFT_IN_PARITY_EN, the PARITY state and the parity_err port SHALL be absent, and frames SHALL be 8 bits.

Structure
REQ-029 FSM state enum and the frame length constant (8) SHALL live in the shared processor package.
REQ-030 The synchronizer SHALL be a sub-module named sync_ff, instantiated three times.

Verification
REQ-031 MSB-first: lsb_first=0, send 0xA5 -> rd_valid after the 8th rise+2 cycles, rd_data=0xA5.
REQ-032 LSB-first: lsb_first=1, send bits 1,0,0,0,0,0,0,0 -> rd_data=0x01.
REQ-033 Overrun: rd_ready=0, send 0x11 then 0x22 back-to-back -> rd_data stays 0x11, overrun=1.
REQ-034 Abort: cs_n high after 5 bits of 0xFF -> rd_valid stays 0, busy returns to 0, the next frame 0x3C is received correctly.
REQ-035 Simultaneous: rd_ready=1 in the DONE cycle of byte 0x55 with 0x44 pending -> rd_valid stays 1, rd_data=0x55, overrun=0.
REQ-036 Parity (macro): 0x07 with parity bit 0 -> rd_data=0x07, parity_err=1; reset mid-frame -> all outputs 0.
